// File: rtl/dcdc_clk_monitor_if.sv
// rtl/dcdc_clk_monitor_if.sv - status/feedback bundle between the switching-clock monitor and the housekeeping bank
//   en            monitor enable (driven by the register bank)
//   clk_in        switching-clock feedback pin, asynchronous to the fabric clock
//   period        last measured period in fabric clock cycles
//   high_time     high time of the last measured period
//   period_valid  one-cycle strobe when period/high_time update
//   locked        frequency within tolerance for enough consecutive periods
//   timeout       sticky loss-of-clock flag
interface dcdc_clk_monitor_if #(
    parameter int WIDTH = 9
);
    logic             en;
    logic             clk_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        input  en,
        input  clk_in,
        output period,
        output high_time,
        output period_valid,
        output locked,
        output timeout
    );

    modport slave (
        output en,
        output clk_in,
        input  period,
        input  high_time,
        input  period_valid,
        input  locked,
        input  timeout
    );
endinterface

// File: rtl/dcdc_clk_monitor.sv
// rtl/dcdc_clk_monitor.sv - measures DC-DC switching-clock feedback period/high time and reports lock and loss of clock
//   clk   fabric clock
//   rst   synchronous active-high reset
//   bus   dcdc_clk_monitor_if.master: en/clk_in in; period, high_time, period_valid, locked, timeout out
module dcdc_clk_monitor #(
    parameter int DIVIDER    = 100,
    parameter int TOLERANCE  = 4,
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 4 * DIVIDER,
    parameter int WIDTH      = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    dcdc_clk_monitor_if.master  bus
);
    localparam int               GW     = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] TMO    = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH:0]   DIV_X  = (WIDTH + 1)'(DIVIDER);
    localparam logic [WIDTH:0]   TOL_X  = (WIDTH + 1)'(TOLERANCE);
    localparam logic [GW-1:0]    LOCK_N = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             s_q, s_d;
    logic             s_dly_q, s_dly_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] h_lat_q, h_lat_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             rise, fall, good;
    logic [WIDTH:0]   cnt_x, diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            s_q            <= 1'b0;
            s_dly_q        <= 1'b0;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            h_lat_q        <= '0;
            good_cnt_q     <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            s_q            <= s_d;
            s_dly_q        <= s_dly_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            h_lat_q        <= h_lat_d;
            good_cnt_q     <= good_cnt_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        // Two-flop synchronizer plus one delay flop for edge detection
        sync1_d = bus.clk_in;
        s_d     = sync1_q;
        s_dly_d = s_q;
        rise    = s_q & ~s_dly_q;
        fall    = ~s_q & s_dly_q;

        // Distance from the programmed divider; one extra bit keeps the subtraction unsigned
        cnt_x = {1'b0, cnt_q};
        diff  = (cnt_x >= DIV_X) ? (cnt_x - DIV_X) : (DIV_X - cnt_x);
        good  = (diff <= TOL_X);

        state_d        = state_q;
        cnt_d          = rise ? ONE : ((cnt_q == TMO) ? cnt_q : cnt_q + ONE);
        hcnt_d         = rise ? ONE : ((s_q && hcnt_q != TMO) ? hcnt_q + ONE : hcnt_q);
        h_lat_d        = fall ? hcnt_q : h_lat_q;
        good_cnt_d     = good_cnt_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = timeout_q;

        if (!bus.en) begin
            // Disable wins over any edge in the same cycle; measurements are kept for software
            state_d    = IDLE;
            cnt_d      = '0;
            hcnt_d     = '0;
            h_lat_d    = '0;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    h_lat_d = '0;
                end
                ACQUIRE: begin
                    // First rise only restarts the counters; the partial period is dropped
                    if (rise) begin
                        state_d   = MEASURE;
                        timeout_d = 1'b0;
                    end else if (cnt_q == TMO) begin
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                    end
                end
                MEASURE: begin
                    // A rise landing on the timeout cycle is measured, not treated as loss of clock
                    if (rise) begin
                        period_d       = cnt_q;
                        high_time_d    = h_lat_q;
                        period_valid_d = 1'b1;
                        if (good) begin
                            good_cnt_d = (good_cnt_q == LOCK_N) ? good_cnt_q : good_cnt_q + GW'(1);
                            locked_d   = (good_cnt_d == LOCK_N);
                        end else begin
                            good_cnt_d = '0;
                            locked_d   = 1'b0;
                        end
                    end else if (cnt_q == TMO) begin
                        state_d    = ACQUIRE;
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.period       = period_q;
    assign bus.high_time    = high_time_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_dcdc_clk_monitor.sv
// tb/tb_dcdc_clk_monitor.sv - directed self-checking bench for dcdc_clk_monitor
module tb_dcdc_clk_monitor;
    localparam int W = $clog2(401);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcdc_clk_monitor_if #(.WIDTH(W)) bus();

    dcdc_clk_monitor #(
        .DIVIDER(100), .TOLERANCE(4), .LOCK_COUNT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Event recorder: strobes and timeout rising edges, timestamped in clk cycles
    int         cyc = 0;
    int         strobes = 0;
    int         strobe_cyc = 0;
    int         to_rises = 0;
    int         to_cyc = 0;
    logic [W-1:0] last_period = '0;
    logic [W-1:0] last_high = '0;
    logic       last_locked = 1'b0;
    logic       locked_at_to = 1'b0;
    logic       to_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.period_valid === 1'b1) begin
            strobes     = strobes + 1;
            strobe_cyc  = cyc;
            last_period = bus.period;
            last_high   = bus.high_time;
            last_locked = bus.locked;
        end
        if (bus.timeout === 1'b1 && to_prev !== 1'b1) begin
            to_rises     = to_rises + 1;
            to_cyc       = cyc;
            locked_at_to = bus.locked;
        end
        to_prev = bus.timeout;
    end

    task automatic pulse(input int h, input int l);
        bus.clk_in = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        bus.clk_in = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.period !== 9'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", bus.period); end
        checks++; if (bus.high_time !== 9'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", bus.high_time); end
        checks++; if ({bus.period_valid, bus.locked, bus.timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.period_valid, bus.locked, bus.timeout}); end
        rst = 1'b0;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_lock();
        pulse(50, 50);
        checks++; if (strobes !== 0) begin errors++; $display("FAIL first_rise_discarded: got %0d strobes expected 0", strobes); end
        pulse(50, 50);
        checks++; if (strobes !== 1) begin errors++; $display("FAIL second_rise_strobe: got %0d strobes expected 1", strobes); end
        checks++; if (last_period !== 9'd100) begin errors++; $display("FAIL basic_period: got %0d expected 100", last_period); end
        checks++; if (last_high !== 9'd50) begin errors++; $display("FAIL basic_high: got %0d expected 50", last_high); end
        for (int i = 0; i < 6; i++) pulse(50, 50);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL not_locked_at_7: got %b expected 0", bus.locked); end
        pulse(50, 50);
        checks++; if (strobes !== 8) begin errors++; $display("FAIL strobe_count_8: got %0d expected 8", strobes); end
        checks++; if (last_locked !== 1'b1) begin errors++; $display("FAIL locked_at_8: got %b expected 1", last_locked); end
    endtask

    task automatic test_bad_period();
        pulse(55, 55);
        pulse(50, 50);
        checks++; if (last_period !== 9'd110) begin errors++; $display("FAIL bad_period: got %0d expected 110", last_period); end
        checks++; if (last_high !== 9'd55) begin errors++; $display("FAIL bad_high: got %0d expected 55", last_high); end
        checks++; if (last_locked !== 1'b0) begin errors++; $display("FAIL bad_unlock: got %b expected 0", last_locked); end
        for (int i = 0; i < 7; i++) pulse(50, 50);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b expected 0", bus.locked); end
        pulse(50, 50);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock_8: got %b expected 1", bus.locked); end
    endtask

    task automatic test_tolerance_edges();
        pulse(60, 60);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) pulse(48, 48);
            else pulse(52, 52);
        end
        checks++; if (last_period !== 9'd96) begin errors++; $display("FAIL tol_period96: got %0d expected 96", last_period); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL tol_not_locked_7: got %b expected 0", bus.locked); end
        pulse(47, 48);
        checks++; if (last_period !== 9'd104) begin errors++; $display("FAIL tol_period104: got %0d expected 104", last_period); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL tol_locked_8: got %b expected 1", bus.locked); end
        pulse(50, 50);
        checks++; if (last_period !== 9'd95) begin errors++; $display("FAIL tol_period95: got %0d expected 95", last_period); end
        checks++; if (last_high !== 9'd47) begin errors++; $display("FAIL tol_high47: got %0d expected 47", last_high); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL tol_drop_95: got %b expected 0", bus.locked); end
    endtask

    task automatic test_timeout();
        int s0;
        int r0;
        for (int i = 0; i < 8; i++) pulse(50, 50);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL to_prelock: got %b expected 1", bus.locked); end
        bus.clk_in = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        bus.clk_in = 1'b0;
        s0 = strobes;
        r0 = to_rises;
        for (int i = 0; i < 500 && to_rises == r0; i++) @(posedge clk);
        #1;
        checks++; if (to_rises !== r0 + 1) begin errors++; $display("FAIL to_asserted: got %0d rises expected %0d", to_rises, r0 + 1); end
        checks++; if (to_cyc - strobe_cyc !== 400) begin errors++; $display("FAIL to_latency: got %0d expected 400", to_cyc - strobe_cyc); end
        checks++; if (locked_at_to !== 1'b0) begin errors++; $display("FAIL to_unlock: got %b expected 0", locked_at_to); end
        checks++; if (strobes !== s0) begin errors++; $display("FAIL to_no_strobe: got %0d expected %0d", strobes, s0); end
        pulse(50, 50);
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_cleared: got %b expected 0", bus.timeout); end
        checks++; if (strobes !== s0) begin errors++; $display("FAIL to_restart_no_strobe: got %0d expected %0d", strobes, s0); end
        pulse(50, 50);
        checks++; if (strobes !== s0 + 1) begin errors++; $display("FAIL to_restart_strobe: got %0d expected %0d", strobes, s0 + 1); end
        checks++; if (last_period !== 9'd100) begin errors++; $display("FAIL to_restart_period: got %0d expected 100", last_period); end
    endtask

    task automatic test_rise_at_timeout();
        int r0;
        r0 = to_rises;
        pulse(50, 350);
        pulse(50, 50);
        checks++; if (last_period !== 9'd400) begin errors++; $display("FAIL edge_period400: got %0d expected 400", last_period); end
        checks++; if (to_rises !== r0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL edge_no_timeout: got %0d rises expected %0d", to_rises, r0); end
        checks++; if (last_locked !== 1'b0) begin errors++; $display("FAIL edge_unlocked: got %b expected 0", last_locked); end
    endtask

    task automatic test_disable();
        int s0;
        for (int i = 0; i < 8; i++) pulse(50, 50);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL en_prelock: got %b expected 1", bus.locked); end
        bus.clk_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({bus.locked, bus.timeout} !== 2'b00) begin errors++; $display("FAIL en_flags: got %b expected 00", {bus.locked, bus.timeout}); end
        checks++; if (bus.period !== 9'd100 || bus.high_time !== 9'd50) begin errors++; $display("FAIL en_hold: got %0d/%0d expected 100/50", bus.period, bus.high_time); end
        bus.clk_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        bus.en = 1'b1;
        s0 = strobes;
        pulse(50, 50);
        checks++; if (strobes !== s0) begin errors++; $display("FAIL en_first_discard: got %0d expected %0d", strobes, s0); end
        pulse(50, 50);
        checks++; if (strobes !== s0 + 1 || last_period !== 9'd100) begin errors++; $display("FAIL en_resume: got %0d strobes period %0d expected %0d/100", strobes, last_period, s0 + 1); end
    endtask

    task automatic test_midrun_reset();
        int s0;
        for (int i = 0; i < 8; i++) pulse(50, 50);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL rst_prelock: got %b expected 1", bus.locked); end
        bus.clk_in = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        bus.clk_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus.locked, bus.timeout} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {bus.locked, bus.timeout}); end
        checks++; if (bus.period !== 9'd0 || bus.high_time !== 9'd0) begin errors++; $display("FAIL rst_clear: got %0d/%0d expected 0/0", bus.period, bus.high_time); end
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        s0 = strobes;
        pulse(50, 50);
        checks++; if (strobes !== s0) begin errors++; $display("FAIL rst_first_discard: got %0d expected %0d", strobes, s0); end
        pulse(50, 50);
        checks++; if (strobes !== s0 + 1 || last_high !== 9'd50) begin errors++; $display("FAIL rst_resume: got %0d strobes high %0d expected %0d/50", strobes, last_high, s0 + 1); end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_bad_period();
        test_tolerance_edges();
        test_timeout();
        test_rise_at_timeout();
        test_disable();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcdc_clk_monitor.md
Name: dcdc_clk_monitor

Overview:
- Receive end of the DC-DC switching-sync interface.
- Takes the converter's switching-clock feedback (asynchronous pin) into the fabric clock domain.
- Measures period and high time in fabric clock cycles.
- Declares lock when the measured frequency matches the programmed divider, and flags loss of the switching clock.
- Status feeds the housekeeping register bank, so software can confirm the converter followed the generated sync clock.

Parameters:
- DIVIDER, 100: expected switching period in clk cycles.
- TOLERANCE, 4: maximum allowed |period - DIVIDER| in cycles for a period to count as good.
- LOCK_COUNT, 8: number of consecutive good periods needed to assert locked.
- TIMEOUT, 4*DIVIDER: cycles without a rising edge before timeout is declared.
- WIDTH, $clog2(TIMEOUT+1): width of the counters and of the measurement outputs.

Ports:
- clk  in  1  fabric clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  monitor enable.
- clk_in  in  1  switching-clock feedback; asynchronous to clk.
- period  out  WIDTH  last measured period, in clk cycles.
- high_time  out  WIDTH  high time of the last measured period, in clk cycles.
- period_valid  out  1  one-cycle strobe; period and high_time updated.
- locked  out  1  frequency within tolerance for LOCK_COUNT consecutive periods.
- timeout  out  1  no rising edge for TIMEOUT cycles; sticky.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst sampled on posedge clk). On reset all outputs, counters, synchronizer flops and the FSM state go to 0/IDLE.
- Synchronizer and edge detection:
  - clk_in passes through 2 flops to give s, then 1 delay flop to give s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A pin edge becomes rise/fall 2-3 clk cycles later. Outputs are registered, so they update on the cycle after rise.
- Period counter cnt (WIDTH bits):
  - On rise, cnt <= 1. Otherwise it increments, saturating at TIMEOUT.
  - Consequence: rises N cycles apart give cnt == N at the second rise.
- High counter hcnt:
  - On rise, hcnt <= 1. Otherwise it increments while s=1, saturating.
  - On fall, h_lat <= hcnt.
- FSM:
  - IDLE:
    - Entered whenever en=0, whatever the current state.
    - Counters are cleared; locked=0 and timeout=0.
    - period and high_time hold their last values.
    - Moves to ACQUIRE when en=1.
  - ACQUIRE:
    - Waits for the first rise. That rise only restarts cnt; the partial period is discarded (no period_valid).
    - Moves to MEASURE on that rise.
  - MEASURE, on each rise:
    - period <= cnt and high_time <= h_lat; period_valid=1 for one cycle.
    - Evaluate the period: diff = |cnt - DIVIDER|, computed in WIDTH+1 bits, unsigned result.
    - If diff <= TOLERANCE: good_cnt increments, saturating at LOCK_COUNT. locked=1 once good_cnt reaches LOCK_COUNT, i.e. on the LOCK_COUNT-th good period.
    - Otherwise: good_cnt=0 and locked=0 on the same strobe.
- Timeout:
  - Condition: in ACQUIRE or MEASURE, cnt reaches TIMEOUT with no rise.
  - Effect: timeout=1, locked=0, good_cnt=0, FSM goes to ACQUIRE, no period_valid.
  - timeout clears on the next rise. That rise is the ACQUIRE rise and produces no strobe.
  - In ACQUIRE, cnt counts from en or from the last rise.
- Simultaneous events:
  - A rise in the same cycle cnt reaches TIMEOUT: the rise wins and is measured normally. period=TIMEOUT, out of tolerance; no timeout.
  - en falling in the same cycle as a rise: IDLE wins, no strobe.
  - rst overrides everything.
- Other edge cases:
  - clk_in stuck high: no further rise, so timeout behaves as above. hcnt saturates; high_time updates only on a strobe.
  - Glitches shorter than one clk cycle may be missed; this is accepted, no filtering is applied.

Test Plan:
- DIVIDER=100: clk_in period 100 cycles, 50% duty, en=1.
  - -> No strobe on the first rise.
  - -> Second rise: period_valid with period=100, high_time=50.
  - -> locked=1 on the 8th strobe.
- Locked at period 100, then a single period of 110 cycles.
  - -> Strobe with period=110; locked=0 and good_cnt=0 on that strobe.
  - -> Relock after 8 further good periods.
- Periods of 96, then 104, repeated.
  - -> All counted as good; locked after 8 strobes.
  - -> Period of 95 drops locked.
- Locked, then clk_in held low.
  - -> timeout=1 and locked=0 exactly 400 cycles after the last rise, with no strobe.
  - -> Restarting clk_in: the first rise clears timeout with no strobe; the next rise strobes.
- rst pulse or en=0 mid-period while locked.
  - -> Next cycle: locked=0, timeout=0.
  - -> With en=0, period and high_time hold. With rst, they read 0.
  - -> On re-enable, the first rise is discarded.
- clk_in rise timed to land exactly when cnt=TIMEOUT.
  - -> period_valid with period=400, timeout stays 0, locked=0.
